// File: rtl/costas_acq_ctrl.sv
// rtl/costas_acq_ctrl.sv - Costas loop frequency-sweep acquisition and lock controller
//
// Purpose: sweeps an NCO frequency offset from F_MIN to F_MAX in STEP increments.
// At each offset it dwells for DWELL_LEN valid samples and counts the good ones.
// If enough samples are good it declares lock (TRACK). TRACK holds the offset
// until UNLOCK_N consecutive bad samples arrive, then the sweep resumes.
//
// Optional feature: define COSTAS_ACQ_STATS_EN to add the lost_count output, a
// saturating count of TRACK->STEP transitions (loss of lock).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-low reset
//   start         in   begin acquisition (honoured only in IDLE)
//   stop          in   abort to IDLE from any state (highest priority)
//   sample_valid  in   strobe: i_filt/q_filt carry a new filtered sample
//   i_filt/q_filt in   signed 32-bit in-phase / quadrature loop-filter outputs
//   freq_offset   out  signed 32-bit NCO phase-increment offset
//   loop_en       out  loop-filter update enable (DWELL/TRACK)
//   locked        out  high only in TRACK
//   state         out  IDLE=0, DWELL=1, STEP=2, TRACK=3
//   byte_valid    out  sample_valid seen in TRACK, delayed one cycle
//   lost_count    out  16-bit loss-of-lock counter (COSTAS_ACQ_STATS_EN only)

module costas_acq_ctrl #(
  parameter logic signed [31:0] STEP      = 32'sd4096,
  parameter logic signed [31:0] F_MIN     = -32'sd1048576,
  parameter logic signed [31:0] F_MAX     = 32'sd1048576,
  parameter int                 DWELL_LEN = 64,
  parameter int                 LOCK_N    = 48,
  parameter int                 UNLOCK_N  = 32,
  parameter logic [31:0]        LOCK_THR  = 32'd1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_valid,
  input  logic signed [31:0] i_filt,
  input  logic signed [31:0] q_filt,
  output logic signed [31:0] freq_offset,
  output logic               loop_en,
  output logic               locked,
  output logic [1:0]         state,
  output logic               byte_valid
`ifdef COSTAS_ACQ_STATS_EN
  ,
  output logic [15:0]        lost_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

  localparam int WIN_W = $clog2(DWELL_LEN + 1);
  localparam int BAD_W = $clog2(UNLOCK_N + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DWELL_LEN - 1);
  localparam logic [WIN_W-1:0] LOCK_CNT = WIN_W'(LOCK_N);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(UNLOCK_N - 1);

  state_t             state_q, state_d;
  logic signed [31:0] freq_q, freq_d;
  logic               loop_en_q, loop_en_d;
  logic               locked_q, locked_d;
  logic               byte_valid_q, byte_valid_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]   good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;

  // |x| with the one unrepresentable magnitude (-2^31) clamped to 2^31-1.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x);
    if (x == 32'sh8000_0000) begin
      return 32'h7FFF_FFFF;
    end else if (x < 0) begin
      return $unsigned(-x);
    end else begin
      return $unsigned(x);
    end
  endfunction

  logic [31:0]        abs_i, abs_q;
  logic               good;
  logic               dwell_done;
  logic               dwell_pass;
  logic               unlock;
  logic [WIN_W-1:0]   good_sum;
  logic signed [32:0] step_sum;
  logic               step_wrap;

  always_comb begin
    abs_i      = sat_abs(i_filt);
    abs_q      = sat_abs(q_filt);
    good       = sample_valid && (abs_i > abs_q) && (abs_i >= LOCK_THR);
    // The terminal sample of the window is counted in the lock decision.
    dwell_done = sample_valid && (win_cnt_q == WIN_LAST);
    good_sum   = good_cnt_q + WIN_W'(good);
    dwell_pass = (good_sum >= LOCK_CNT);
    unlock     = sample_valid && !good && (bad_cnt_q == BAD_LAST);
    // One extra bit so the sum near the top of the range cannot overflow.
    step_sum   = 33'(freq_q) + 33'(STEP);
    step_wrap  = (step_sum > 33'(F_MAX));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_DWELL;
        ST_DWELL: if (dwell_done) state_d = dwell_pass ? ST_TRACK : ST_STEP;
        ST_STEP:  state_d = ST_DWELL;
        ST_TRACK: if (unlock) state_d = ST_STEP;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath logic; registered outputs are computed from the
  // next state so they change on the same edge as the state register.
  always_comb begin
    freq_d       = freq_q;
    win_cnt_d    = win_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    loop_en_d    = (state_d == ST_DWELL) || (state_d == ST_TRACK);
    locked_d     = (state_d == ST_TRACK);
    // A sample on the cycle that leaves TRACK is not forwarded.
    byte_valid_d = sample_valid && (state_q == ST_TRACK) && (state_d == ST_TRACK);

    if (stop) begin
      freq_d     = '0;
      win_cnt_d  = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            freq_d     = F_MIN;
            win_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end
        end
        ST_DWELL: begin
          if (dwell_done) begin
            win_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else if (sample_valid) begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            good_cnt_d = good_sum;
          end
        end
        ST_STEP: begin
          freq_d     = step_wrap ? F_MIN : step_sum[31:0];
          win_cnt_d  = '0;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
        ST_TRACK: begin
          if (sample_valid) begin
            if (good || unlock) begin
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end
        end
        default: begin
          freq_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_q       <= '0;
      loop_en_q    <= 1'b0;
      locked_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      win_cnt_q    <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
    end else begin
      freq_q       <= freq_d;
      loop_en_q    <= loop_en_d;
      locked_q     <= locked_d;
      byte_valid_q <= byte_valid_d;
      win_cnt_q    <= win_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

`ifdef COSTAS_ACQ_STATS_EN
  logic [15:0] lost_count_q, lost_count_d;

  // Only a genuine loss of lock counts; stop out of TRACK does not.
  always_comb begin
    lost_count_d = lost_count_q;
    if ((state_q == ST_TRACK) && (state_d == ST_STEP) && (lost_count_q != 16'hFFFF)) begin
      lost_count_d = lost_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lost_count_q <= '0;
    end else begin
      lost_count_q <= lost_count_d;
    end
  end

  assign lost_count = lost_count_q;
`endif

  assign freq_offset = freq_q;
  assign loop_en     = loop_en_q;
  assign locked      = locked_q;
  assign state       = state_q;
  assign byte_valid  = byte_valid_q;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// tb/tb_costas_acq_ctrl.sv - self-checking bench for costas_acq_ctrl
module tb_costas_acq_ctrl;

  localparam longint STEP      = 4096;
  localparam longint F_MIN     = -1048576;
  localparam longint F_MAX     = 1048576;
  localparam int     DWELL_LEN = 64;
  localparam int     LOCK_N    = 48;
  localparam int     UNLOCK_N  = 32;
  localparam longint LOCK_THR  = 1048576;

  localparam logic signed [31:0] BIG  = 32'sd2097152;
  localparam logic signed [31:0] NEG  = 32'sh8000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, stop, sample_valid;
  logic signed [31:0] i_filt, q_filt;
  logic signed [31:0] freq_offset;
  logic               loop_en, locked, byte_valid;
  logic [1:0]         state;
`ifdef COSTAS_ACQ_STATS_EN
  logic [15:0]        lost_count;
`endif

  costas_acq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .sample_valid(sample_valid), .i_filt(i_filt), .q_filt(q_filt),
    .freq_offset(freq_offset), .loop_en(loop_en), .locked(locked),
    .state(state), .byte_valid(byte_valid)
`ifdef COSTAS_ACQ_STATS_EN
    , .lost_count(lost_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode number, offset as a wide integer, the current
  // dwell window as a queue of good/bad flags, and a bad-run length.
  int     m_state;
  longint m_freq;
  bit     m_win[$];
  int     m_bad;
  bit     m_bv;
  int     m_lost;

  function automatic longint mag(input logic signed [31:0] x);
    longint a;
    a = x;
    if (a < 0) a = -a;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    return a;
  endfunction

  function automatic bit is_good(input bit sv, input logic signed [31:0] i, input logic signed [31:0] q);
    return sv && (mag(i) > mag(q)) && (mag(i) >= LOCK_THR);
  endfunction

  task automatic model_reset();
    m_state = 0; m_freq = 0; m_win.delete(); m_bad = 0; m_bv = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit sv,
                            input logic signed [31:0] i, input logic signed [31:0] q);
    bit g;
    int goods;
    g = is_good(sv, i, q);
    m_bv = 0;
    if (sp) begin
      m_state = 0; m_freq = 0; m_win.delete(); m_bad = 0;
    end else begin
      case (m_state)
        0: if (st) begin m_state = 1; m_freq = F_MIN; m_win.delete(); m_bad = 0; end
        1: if (sv) begin
             m_win.push_back(g);
             if (m_win.size() == DWELL_LEN) begin
               goods = 0;
               foreach (m_win[k]) goods += int'(m_win[k]);
               m_state = (goods >= LOCK_N) ? 3 : 2;
               m_win.delete();
               m_bad = 0;
             end
           end
        2: begin
             m_freq  = (m_freq + STEP > F_MAX) ? F_MIN : m_freq + STEP;
             m_state = 1;
           end
        default: if (sv) begin
             m_bad = g ? 0 : m_bad + 1;
             if (m_bad == UNLOCK_N) begin
               m_state = 2; m_bad = 0;
               if (m_lost < 65535) m_lost++;
             end else begin
               m_bv = 1;
             end
           end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_lost();
`ifdef COSTAS_ACQ_STATS_EN
    return lost_count;
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] exp_lost();
`ifdef COSTAS_ACQ_STATS_EN
    return 16'(m_lost);
`else
    return 16'h0;
`endif
  endfunction

  task automatic check_model(input string name);
    check(name,
          {11'd0, state, freq_offset, loop_en, locked, byte_valid, dut_lost()},
          {11'd0, 2'(m_state), 32'(m_freq), (m_state == 1 || m_state == 3), (m_state == 3), m_bv, exp_lost()});
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after.
  task automatic cyc(input bit st, input bit sp, input bit sv,
                     input logic signed [31:0] i, input logic signed [31:0] q);
    start = st; stop = sp; sample_valid = sv; i_filt = i; q_filt = q;
    @(posedge clk);
    model_step(st, sp, sv, i, q);
    #1;
    check_model("model");
  endtask

  typedef struct {
    bit                 st, sp, sv;
    logic signed [31:0] i, q;
    logic [1:0]         e_state;
    logic signed [31:0] e_freq;
    bit                 e_loop, e_locked;
  } vec_t;

  vec_t tbl[8];
  logic signed [31:0] fmin32;
  bit saw_max, saw_wrap;
  int pgood;
  logic signed [31:0] ri, rq;

  initial begin
    fmin32 = 32'(F_MIN);
    tbl[0] = '{1, 1, 0, 32'sd0, 32'sd0, 2'd0, 32'sd0,  0, 0};
    tbl[1] = '{0, 0, 1, BIG,    32'sd0, 2'd0, 32'sd0,  0, 0};
    tbl[2] = '{1, 0, 0, 32'sd0, 32'sd0, 2'd1, fmin32,  1, 0};
    tbl[3] = '{0, 0, 1, BIG,    32'sd0, 2'd1, fmin32,  1, 0};
    tbl[4] = '{1, 0, 0, 32'sd0, 32'sd0, 2'd1, fmin32,  1, 0};
    tbl[5] = '{0, 1, 0, 32'sd0, 32'sd0, 2'd0, 32'sd0,  0, 0};
    tbl[6] = '{1, 0, 1, BIG,    32'sd0, 2'd1, fmin32,  1, 0};
    tbl[7] = '{1, 1, 1, BIG,    32'sd0, 2'd0, 32'sd0,  0, 0};

    rst = 1'b0; start = 0; stop = 0; sample_valid = 0; i_filt = 0; q_filt = 0;
    model_reset();
    #1;
    check("reset_outputs", {27'd0, state, freq_offset, loop_en, locked, byte_valid, dut_lost()}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Table vectors: start/stop priority, sample_valid ignored in IDLE
    for (int k = 0; k < 8; k++) begin
      cyc(tbl[k].st, tbl[k].sp, tbl[k].sv, tbl[k].i, tbl[k].q);
      check($sformatf("tbl%0d", k), {26'd0, state, freq_offset, loop_en, locked},
            {26'd0, tbl[k].e_state, tbl[k].e_freq, tbl[k].e_loop, tbl[k].e_locked});
    end

    // Lock on a strong in-phase signal after exactly 64 valids
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < DWELL_LEN - 1; k++) cyc(0, 0, 1, BIG, 0);
    check("pre_lock_state", 64'(state), 64'd1);
    cyc(0, 0, 1, BIG, 0);
    check("lock", {29'd0, state, locked, freq_offset}, {29'd0, 2'd3, 1'b1, fmin32});

    // byte_valid follows sample_valid by one cycle in TRACK
    cyc(0, 0, 1, BIG, 0);
    check("bv_high", 64'(byte_valid), 64'd1);
    cyc(0, 0, 0, BIG, 0);
    check("bv_low", 64'(byte_valid), 64'd0);

    // 31 bad, 1 good, 31 bad stays locked; one more bad unlocks
    for (int k = 0; k < UNLOCK_N - 1; k++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, BIG, 0);
    for (int k = 0; k < UNLOCK_N - 1; k++) cyc(0, 0, 1, 0, 0);
    check("still_track", 64'(state), 64'd3);
    cyc(0, 0, 1, 0, 0);
    check("unlock", {61'd0, state, byte_valid}, {61'd0, 2'd2, 1'b0});
`ifdef COSTAS_ACQ_STATS_EN
    check("lost_one", 64'(lost_count), 64'd1);
`endif
    cyc(0, 0, 1, BIG, 0);
    check("step_then_dwell", {state, byte_valid, freq_offset}, {2'd1, 1'b0, 32'(F_MIN + STEP)});

    // Saturated |-2^31| counts as good; async reset mid-TRACK
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < DWELL_LEN; k++) cyc(0, 0, 1, NEG, 0);
    check("neg_lock", 64'(state), 64'd3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_reset", {27'd0, state, freq_offset, loop_en, locked, byte_valid, dut_lost()}, 64'd0);
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, BIG, 0);
    check("idle_after_reset", 64'(state), 64'd0);

    // Full sweep with no signal, through the wrap
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < DWELL_LEN; k++) cyc(0, 0, 1, 0, 0);
    check("first_step", {30'd0, state, freq_offset}, {30'd0, 2'd2, fmin32});
    cyc(0, 0, 1, 0, 0);
    check("second_offset", {30'd0, state, freq_offset}, {30'd0, 2'd1, 32'(F_MIN + STEP)});
    saw_max = 0; saw_wrap = 0;
    for (int n = 0; n < 40000 && !saw_wrap; n++) begin
      cyc(0, 0, 1, 0, 0);
      if (freq_offset == 32'(F_MAX)) saw_max = 1;
      if (saw_max && freq_offset == fmin32 && state == 2'd1) saw_wrap = 1;
    end
    check("sweep_reached_max", 64'(saw_max), 64'd1);
    check("sweep_wrapped", 64'(saw_wrap), 64'd1);

    // Randomized phases against the model
    cyc(0, 1, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: pgood = 95;
          1: pgood = 70;
          default: pgood = 10;
        endcase
      end
      if ($urandom_range(0, 99) < pgood) begin
        ri = 32'(LOCK_THR) + 32'($urandom_range(0, 16777216));
        if ($urandom_range(0, 1) == 1) ri = -ri;
        if ($urandom_range(0, 30) == 0) ri = NEG;
        rq = 32'($urandom_range(0, 65535));
      end else begin
        case ($urandom_range(0, 3))
          0: begin ri = 0; rq = 32'($urandom); end
          1: begin ri = 32'(LOCK_THR); rq = ri; end
          2: begin ri = 32'(LOCK_THR - 1); rq = 0; end
          default: begin ri = NEG; rq = 32'sh7FFF_FFFF; end
        endcase
      end
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
          $urandom_range(0, 3) != 0, ri, rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
